pipelined_control_unit: RTL and testbench
=========================================

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-address width (4 for RV32E).
REQ-002 SHALL have parameter FWD_EN, default 1; 1 = forwarding, 0 = stall on every RAW hazard.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port opcode_d  in  7  instruction opcode, decode stage.
REQ-006 SHALL have ports rs1_d, rs2_d, rd_d  in  REG_W each  register addresses, decode stage.
REQ-007 SHALL have port branch_cond_e  in  1  datapath comparison result (funct3-resolved), execute stage.
REQ-008 SHALL have port imm_src_d  out  3  extender select: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-009 SHALL have ports alu_src_e (1), alu_a_pc_e (1), aluop_e (2)  out  execute-stage ALU controls.
REQ-010 SHALL have ports memwrite_m (1), regwrite_m (1), rd_m (REG_W)  out  memory-stage controls.
REQ-011 SHALL have ports regwrite_w (1), result_src_w (2), rd_w (REG_W)  out  writeback controls; result_src 00 ALU, 01 mem, 10 PC+4, 11 imm.
REQ-012 SHALL have ports pc_src_e, stall_f, stall_d, flush_d, flush_e  out  1 each  hazard controls.
REQ-013 SHALL have ports forward_a_e, forward_b_e  out  2 each  00 regfile, 01 W result, 10 M ALU result.

Function
REQ-014 Decode SHALL be combinational on opcode_d: R 0110011, load 0000011, store 0100011, branch 1100011, I-ALU 0010011, JAL 1101111, JALR 1100111 as existing decoder; LUI 0110111: regwrite, imm_src 100, result_src 11; AUIPC 0010111: regwrite, alu_src, alu_a_pc, imm_src 100, aluop 00; other opcodes: all controls 0.
REQ-015 D->E, E->M, M->W registers SHALL carry controls, rd, and (D->E) rs1/rs2; latency D to W = 3 cycles.
REQ-016 D->E register SHALL load zeros (bubble) when flush_e=1; E->M and M->W SHALL load every cycle.
REQ-017 pc_src_e SHALL equal (branch_e AND branch_cond_e) OR jump_e, combinational.
REQ-018 lw_stall SHALL be result_src_e==01 AND rd_e!=0 AND (rd_e==rs1_d OR rd_e==rs2_d).
REQ-019 If FWD_EN=0, raw_stall SHALL be regwrite_e/regwrite_m with rd!=0 matching rs1_d or rs2_d; stall term = lw_stall OR raw_stall; if FWD_EN=1, stall term = lw_stall.
REQ-020 stall_f = stall_d = stall term; flush_d = pc_src_e; flush_e = stall term OR pc_src_e.
REQ-021 Simultaneous stall and pc_src_e: flush_d SHALL dominate stall_d in the datapath; both outputs asserted.
REQ-022 forward_a_e SHALL be 10 if regwrite_m, rd_m!=0, rd_m==rs1_e; else 01 if regwrite_w, rd_w!=0, rd_w==rs1_e; else 00; forward_b_e same on rs2_e; M has priority.
REQ-023 With FWD_EN=0 forward outputs SHALL be constant 00.
REQ-024 Register x0 SHALL never trigger stall or forwarding.

Reset
REQ-025 With rst_n=0 at a clock edge all pipeline registers SHALL clear to 0; all registered outputs 0, forward 00, pc_src_e 0.
REQ-026 Reset mid-operation SHALL discard in-flight controls; no regwrite_w/memwrite_m asserted the cycle after reset.

Structure
REQ-027 Opcodes, imm_src/result_src/forward encodings SHALL live in shared package rv_ctrl_pkg.
REQ-028 Combinational decoder SHALL be sub-module main_decoder; hazard/forward logic and pipeline registers in this module.

Verification
REQ-029 add x5,x1,x2 then sub x6,x5,x3 -> forward_a_e=10 on sub in E; next-but-one use -> 01.
REQ-030 lw x5,0(x1) then add x6,x5,x2 -> stall_f=stall_d=flush_e=1 one cycle, then forward_a_e=01.
REQ-031 beq with branch_cond_e=1 -> pc_src_e=1, flush_d=flush_e=1 same cycle; cond 0 -> all 0.
REQ-032 LUI x7 -> imm_src_d=100, result_src_w=11, regwrite_w=1 exactly 3 cycles later; opcode 1111111 -> all controls 0.
REQ-033 rd=x0 producer followed by x0 consumer -> forward 00, no stall; FWD_EN=0 add/sub pair -> two stall cycles.
REQ-034 rst_n=0 with store in M -> memwrite_m=0 next edge, all outputs zero.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_ctrl_pkg
//  Brief    : Opcodes, select encodings and the decoded-control bundle shared
//             by the RV32 pipelined control unit and its decoder.
//  Revision : 1.0  initial release
// ============================================================================
package rv_ctrl_pkg;

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_IALU   = 7'b0010011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] C_IMM_I = 3'b000;
  localparam logic [2:0] C_IMM_S = 3'b001;
  localparam logic [2:0] C_IMM_B = 3'b010;
  localparam logic [2:0] C_IMM_J = 3'b011;
  localparam logic [2:0] C_IMM_U = 3'b100;

  localparam logic [1:0] C_RES_ALU = 2'b00;
  localparam logic [1:0] C_RES_MEM = 2'b01;
  localparam logic [1:0] C_RES_PC4 = 2'b10;
  localparam logic [1:0] C_RES_IMM = 2'b11;

  localparam logic [1:0] C_FWD_RF = 2'b00;
  localparam logic [1:0] C_FWD_W  = 2'b01;
  localparam logic [1:0] C_FWD_M  = 2'b10;

  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] result_src;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic [1:0] aluop;
    logic       alu_src;
    logic       alu_a_pc;
    logic [2:0] imm_src;
  } ctrl_t;

  localparam ctrl_t C_CTRL_NONE = '0;

endpackage
`default_nettype wire

// File: rtl/main_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : main_decoder
//  Brief    : Combinational opcode decoder producing the decode-stage control
//             bundle; unknown opcodes decode to all-zero controls.
//  Revision : 1.0  initial release
// ============================================================================
module main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = C_CTRL_NONE;
    case (opcode)
      C_OP_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = C_ALUOP_FUNCT;
      end
      C_OP_LOAD: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = C_RES_MEM;
        ctrl.imm_src    = C_IMM_I;
      end
      C_OP_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.imm_src  = C_IMM_S;
      end
      C_OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.aluop   = C_ALUOP_SUB;
        ctrl.imm_src = C_IMM_B;
      end
      C_OP_IALU: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.aluop    = C_ALUOP_FUNCT;
        ctrl.imm_src  = C_IMM_I;
      end
      C_OP_JAL: begin
        ctrl.regwrite   = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = C_RES_PC4;
        ctrl.imm_src    = C_IMM_J;
      end
      // JALR target comes out of the ALU as rs1 + I-immediate
      C_OP_JALR: begin
        ctrl.regwrite   = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = C_RES_PC4;
        ctrl.imm_src    = C_IMM_I;
      end
      C_OP_LUI: begin
        ctrl.regwrite   = 1'b1;
        ctrl.result_src = C_RES_IMM;
        ctrl.imm_src    = C_IMM_U;
      end
      C_OP_AUIPC: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_a_pc = 1'b1;
        ctrl.aluop    = C_ALUOP_ADD;
        ctrl.imm_src  = C_IMM_U;
      end
      default: ctrl = C_CTRL_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_control_unit
//  Brief    : Five-stage RV32 control path: decode, D/E/M/W control registers,
//             load-use / RAW stall, branch flush and operand forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int FWD_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode_d,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_d,
  input  logic             branch_cond_e,
  output logic [2:0]       imm_src_d,
  output logic             alu_src_e,
  output logic             alu_a_pc_e,
  output logic [1:0]       aluop_e,
  output logic             memwrite_m,
  output logic             regwrite_m,
  output logic [REG_W-1:0] rd_m,
  output logic             regwrite_w,
  output logic [1:0]       result_src_w,
  output logic [REG_W-1:0] rd_w,
  output logic             pc_src_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e
);

  ctrl_t w_ctrl_d;

  main_decoder u_main_decoder (
    .opcode (opcode_d),
    .ctrl   (w_ctrl_d)
  );

  assign imm_src_d = w_ctrl_d.imm_src;

  logic             r_regwrite_e, r_memwrite_e, r_jump_e, r_branch_e;
  logic             r_alu_src_e, r_alu_a_pc_e;
  logic [1:0]       r_result_src_e, r_aluop_e;
  logic [REG_W-1:0] r_rd_e, r_rs1_e, r_rs2_e;
  logic             r_regwrite_m, r_memwrite_m;
  logic [1:0]       r_result_src_m;
  logic [REG_W-1:0] r_rd_m;
  logic             r_regwrite_w;
  logic [1:0]       r_result_src_w;
  logic [REG_W-1:0] r_rd_w;
  logic             w_lw_stall, w_stall;

  // D->E: a flush turns the incoming instruction into a bubble
  always_ff @(posedge clk) begin
    if (!rst_n || flush_e) begin
      r_regwrite_e   <= 1'b0;
      r_result_src_e <= 2'b00;
      r_memwrite_e   <= 1'b0;
      r_jump_e       <= 1'b0;
      r_branch_e     <= 1'b0;
      r_aluop_e      <= 2'b00;
      r_alu_src_e    <= 1'b0;
      r_alu_a_pc_e   <= 1'b0;
      r_rd_e         <= '0;
      r_rs1_e        <= '0;
      r_rs2_e        <= '0;
    end else begin
      r_regwrite_e   <= w_ctrl_d.regwrite;
      r_result_src_e <= w_ctrl_d.result_src;
      r_memwrite_e   <= w_ctrl_d.memwrite;
      r_jump_e       <= w_ctrl_d.jump;
      r_branch_e     <= w_ctrl_d.branch;
      r_aluop_e      <= w_ctrl_d.aluop;
      r_alu_src_e    <= w_ctrl_d.alu_src;
      r_alu_a_pc_e   <= w_ctrl_d.alu_a_pc;
      r_rd_e         <= rd_d;
      r_rs1_e        <= rs1_d;
      r_rs2_e        <= rs2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regwrite_m   <= 1'b0;
      r_memwrite_m   <= 1'b0;
      r_result_src_m <= 2'b00;
      r_rd_m         <= '0;
      r_regwrite_w   <= 1'b0;
      r_result_src_w <= 2'b00;
      r_rd_w         <= '0;
    end else begin
      r_regwrite_m   <= r_regwrite_e;
      r_memwrite_m   <= r_memwrite_e;
      r_result_src_m <= r_result_src_e;
      r_rd_m         <= r_rd_e;
      r_regwrite_w   <= r_regwrite_m;
      r_result_src_w <= r_result_src_m;
      r_rd_w         <= r_rd_m;
    end
  end

  assign pc_src_e   = (r_branch_e & branch_cond_e) | r_jump_e;
  assign w_lw_stall = (r_result_src_e == C_RES_MEM) && (r_rd_e != '0) &&
                      ((r_rd_e == rs1_d) || (r_rd_e == rs2_d));

  generate
    if (FWD_EN != 0) begin : g_fwd
      assign w_stall = w_lw_stall;

      // M-stage producer is younger than W, so it wins
      always_comb begin
        forward_a_e = C_FWD_RF;
        if (r_regwrite_m && (r_rd_m != '0) && (r_rd_m == r_rs1_e))
          forward_a_e = C_FWD_M;
        else if (r_regwrite_w && (r_rd_w != '0) && (r_rd_w == r_rs1_e))
          forward_a_e = C_FWD_W;
      end

      always_comb begin
        forward_b_e = C_FWD_RF;
        if (r_regwrite_m && (r_rd_m != '0) && (r_rd_m == r_rs2_e))
          forward_b_e = C_FWD_M;
        else if (r_regwrite_w && (r_rd_w != '0) && (r_rd_w == r_rs2_e))
          forward_b_e = C_FWD_W;
      end
    end else begin : g_no_fwd
      logic w_raw_e, w_raw_m;
      assign w_raw_e = r_regwrite_e && (r_rd_e != '0) &&
                       ((r_rd_e == rs1_d) || (r_rd_e == rs2_d));
      assign w_raw_m = r_regwrite_m && (r_rd_m != '0) &&
                       ((r_rd_m == rs1_d) || (r_rd_m == rs2_d));
      assign w_stall     = w_lw_stall | w_raw_e | w_raw_m;
      assign forward_a_e = C_FWD_RF;
      assign forward_b_e = C_FWD_RF;
    end
  endgenerate

  assign stall_f = w_stall;
  assign stall_d = w_stall;
  assign flush_d = pc_src_e;
  assign flush_e = w_stall | pc_src_e;

  assign alu_src_e    = r_alu_src_e;
  assign alu_a_pc_e   = r_alu_a_pc_e;
  assign aluop_e      = r_aluop_e;
  assign memwrite_m   = r_memwrite_m;
  assign regwrite_m   = r_regwrite_m;
  assign rd_m         = r_rd_m;
  assign regwrite_w   = r_regwrite_w;
  assign result_src_w = r_result_src_w;
  assign rd_w         = r_rd_w;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_control_unit
//  Brief    : Directed self-checking bench for the forwarding and the
//             stall-only configurations of the pipelined control unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;
  localparam logic [6:0] OP_NONE   = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       branch_cond_e;
  logic [2:0] imm_src_d;
  logic       alu_src_e, alu_a_pc_e, memwrite_m, regwrite_m, regwrite_w;
  logic [1:0] aluop_e, result_src_w, forward_a_e, forward_b_e;
  logic [4:0] rd_m, rd_w;
  logic       pc_src_e, stall_f, stall_d, flush_d, flush_e;

  logic [6:0] b_opcode_d;
  logic [4:0] b_rs1_d, b_rs2_d, b_rd_d;
  logic [2:0] b_imm_src_d;
  logic       b_alu_src_e, b_alu_a_pc_e, b_memwrite_m, b_regwrite_m, b_regwrite_w;
  logic [1:0] b_aluop_e, b_result_src_w, b_forward_a_e, b_forward_b_e;
  logic [4:0] b_rd_m, b_rd_w;
  logic       b_pc_src_e, b_stall_f, b_stall_d, b_flush_d, b_flush_e;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_control_unit #(.REG_W(5), .FWD_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_d(rd_d), .branch_cond_e(branch_cond_e), .imm_src_d(imm_src_d),
    .alu_src_e(alu_src_e), .alu_a_pc_e(alu_a_pc_e), .aluop_e(aluop_e),
    .memwrite_m(memwrite_m), .regwrite_m(regwrite_m), .rd_m(rd_m),
    .regwrite_w(regwrite_w), .result_src_w(result_src_w), .rd_w(rd_w),
    .pc_src_e(pc_src_e), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
  );

  pipelined_control_unit #(.REG_W(5), .FWD_EN(0)) u_dut_nofwd (
    .clk(clk), .rst_n(rst_n), .opcode_d(b_opcode_d), .rs1_d(b_rs1_d), .rs2_d(b_rs2_d),
    .rd_d(b_rd_d), .branch_cond_e(1'b0), .imm_src_d(b_imm_src_d),
    .alu_src_e(b_alu_src_e), .alu_a_pc_e(b_alu_a_pc_e), .aluop_e(b_aluop_e),
    .memwrite_m(b_memwrite_m), .regwrite_m(b_regwrite_m), .rd_m(b_rd_m),
    .regwrite_w(b_regwrite_w), .result_src_w(b_result_src_w), .rd_w(b_rd_w),
    .pc_src_e(b_pc_src_e), .stall_f(b_stall_f), .stall_d(b_stall_d), .flush_d(b_flush_d),
    .flush_e(b_flush_e), .forward_a_e(b_forward_a_e), .forward_b_e(b_forward_b_e)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] s1,
                       input logic [4:0] s2);
    opcode_d = op; rd_d = rd; rs1_d = s1; rs2_d = s2;
  endtask

  task automatic b_issue(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] s1,
                         input logic [4:0] s2);
    b_opcode_d = op; b_rd_d = rd; b_rs1_d = s1; b_rs2_d = s2;
  endtask

  initial begin
    rst_n = 1'b0;
    branch_cond_e = 1'b0;
    issue(OP_NONE, 0, 0, 0);
    b_issue(OP_NONE, 0, 0, 0);
    tick();
    tick();
    chk("rst_regwrite_w", regwrite_w, 0);
    chk("rst_memwrite_m", memwrite_m, 0);
    chk("rst_fwd_a", forward_a_e, 0);
    chk("rst_pc_src", pc_src_e, 0);
    chk("rst_stall_d", stall_d, 0);
    chk("rst_b_regwrite_w", b_regwrite_w, 0);
    rst_n = 1'b1;

    // add x5,x1,x2 ; sub x6,x5,x3 ; or x7,x4,x5
    issue(OP_R, 5, 1, 2);
    tick();
    chk("add_aluop_e", aluop_e, 2);
    chk("add_alu_src_e", alu_src_e, 0);
    issue(OP_R, 6, 5, 3);
    settle();
    chk("sub_no_stall", stall_d, 0);
    tick();
    chk("sub_fwd_a_m", forward_a_e, 2);
    chk("sub_fwd_b", forward_b_e, 0);
    chk("add_rd_m", rd_m, 5);
    issue(OP_R, 7, 4, 5);
    tick();
    chk("or_fwd_a", forward_a_e, 0);
    chk("or_fwd_b_w", forward_b_e, 1);
    chk("add_regwrite_w", regwrite_w, 1);
    chk("add_rd_w", rd_w, 5);

    // two producers of x5 in M and W: M wins
    issue(OP_R, 5, 1, 1);
    tick();
    issue(OP_R, 5, 2, 2);
    tick();
    issue(OP_R, 8, 5, 5);
    tick();
    chk("prio_fwd_a", forward_a_e, 2);
    chk("prio_fwd_b", forward_b_e, 2);

    // lw x5,0(x1) ; add x6,x5,x2
    issue(OP_LOAD, 5, 1, 0);
    tick();
    chk("lw_alu_src_e", alu_src_e, 1);
    issue(OP_R, 6, 5, 2);
    settle();
    chk("lw_stall_f", stall_f, 1);
    chk("lw_stall_d", stall_d, 1);
    chk("lw_flush_e", flush_e, 1);
    chk("lw_flush_d", flush_d, 0);
    tick();
    chk("lw_stall_end", stall_d, 0);
    chk("lw_bubble_aluop", aluop_e, 0);
    chk("lw_regwrite_m", regwrite_m, 1);
    tick();
    chk("lw_use_fwd_a", forward_a_e, 1);
    chk("lw_result_src_w", result_src_w, 1);

    // beq taken / not taken
    issue(OP_BRANCH, 0, 1, 2);
    settle();
    chk("beq_imm_src", imm_src_d, 2);
    tick();
    branch_cond_e = 1'b1;
    settle();
    chk("beq_t_pc_src", pc_src_e, 1);
    chk("beq_t_flush_d", flush_d, 1);
    chk("beq_t_flush_e", flush_e, 1);
    chk("beq_t_stall_d", stall_d, 0);
    branch_cond_e = 1'b0;
    settle();
    chk("beq_n_pc_src", pc_src_e, 0);
    chk("beq_n_flush_d", flush_d, 0);
    chk("beq_n_flush_e", flush_e, 0);
    issue(OP_NONE, 0, 0, 0);
    tick();

    // jal x1 redirects regardless of the comparison result
    issue(OP_JAL, 1, 0, 0);
    settle();
    chk("jal_imm_src", imm_src_d, 3);
    tick();
    issue(OP_NONE, 0, 0, 0);
    settle();
    chk("jal_pc_src", pc_src_e, 1);
    tick();
    tick();
    chk("jal_result_src_w", result_src_w, 2);
    chk("jal_rd_w", rd_w, 1);

    // lui x7 reaches writeback exactly three edges after decode
    issue(OP_LUI, 7, 0, 0);
    settle();
    chk("lui_imm_src", imm_src_d, 4);
    tick();
    issue(OP_NONE, 0, 0, 0);
    tick();
    chk("lui_not_yet_w", regwrite_w, 0);
    chk("lui_regwrite_m", regwrite_m, 1);
    tick();
    chk("lui_regwrite_w", regwrite_w, 1);
    chk("lui_result_src_w", result_src_w, 3);
    chk("lui_rd_w", rd_w, 7);

    // unknown opcode decodes to nothing
    issue(OP_BAD, 9, 1, 2);
    settle();
    chk("bad_imm_src", imm_src_d, 0);
    tick();
    chk("bad_alu_src", alu_src_e, 0);
    chk("bad_aluop", aluop_e, 0);
    issue(OP_NONE, 0, 0, 0);
    tick();
    chk("bad_regwrite_m", regwrite_m, 0);

    // auipc x3
    issue(OP_AUIPC, 3, 0, 0);
    settle();
    chk("auipc_imm_src", imm_src_d, 4);
    tick();
    chk("auipc_alu_src", alu_src_e, 1);
    chk("auipc_alu_a_pc", alu_a_pc_e, 1);
    chk("auipc_aluop", aluop_e, 0);

    // x0 producers never forward or stall
    issue(OP_R, 0, 1, 2);
    tick();
    issue(OP_R, 6, 0, 0);
    settle();
    chk("x0_no_stall", stall_d, 0);
    tick();
    chk("x0_fwd_a", forward_a_e, 0);
    chk("x0_fwd_b", forward_b_e, 0);
    issue(OP_LOAD, 0, 1, 0);
    tick();
    issue(OP_R, 6, 0, 0);
    settle();
    chk("x0_lw_no_stall", stall_d, 0);
    tick();

    // reset with a store in M and an add in W
    issue(OP_R, 4, 1, 2);
    tick();
    issue(OP_STORE, 0, 1, 2);
    tick();
    issue(OP_LOAD, 5, 1, 0);
    tick();
    chk("pre_rst_memwrite_m", memwrite_m, 1);
    chk("pre_rst_regwrite_w", regwrite_w, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_memwrite_m", memwrite_m, 0);
    chk("mid_rst_regwrite_w", regwrite_w, 0);
    chk("mid_rst_regwrite_m", regwrite_m, 0);
    chk("mid_rst_alu_src_e", alu_src_e, 0);
    chk("mid_rst_rd_w", rd_w, 0);
    rst_n = 1'b1;
    issue(OP_NONE, 0, 0, 0);
    tick();

    // stall-only build: add/sub pair stalls for two cycles
    b_issue(OP_R, 5, 1, 2);
    tick();
    b_issue(OP_R, 6, 5, 3);
    settle();
    chk("nf_stall_1", b_stall_d, 1);
    chk("nf_stall_f_1", b_stall_f, 1);
    chk("nf_flush_e_1", b_flush_e, 1);
    tick();
    chk("nf_stall_2", b_stall_d, 1);
    chk("nf_regwrite_m", b_regwrite_m, 1);
    tick();
    chk("nf_stall_done", b_stall_d, 0);
    tick();
    chk("nf_fwd_a", b_forward_a_e, 0);
    chk("nf_fwd_b", b_forward_b_e, 0);
    chk("nf_sub_aluop", b_aluop_e, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
